aximm_leader_traffic_gen: RTL and testbench

Parametrised AXI4 memory-mapped leader traffic generator for the AXI-MM full examples. It issues one write burst or one read burst per command, with a deterministic data pattern, correct AXI4 beat counting (awlen+1 beats) and bus-width-derived size and strobes. It checks B/R responses and, optionally, compares read data against the same pattern. It sits between the example test controller and the AXI-MM leader adapter's user_* interface.

---
 rtl/aximm_leader_traffic_gen_if.sv | 66 ++++++
 rtl/aximm_leader_traffic_gen.sv | 255 +++++++++++++++++++++++++
 tb/tb_aximm_leader_traffic_gen.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aximm_leader_traffic_gen_if.sv
// AXI4 memory-mapped user_* bus between the traffic generator (master) and the leader adapter (slave).
interface aximm_leader_traffic_gen_if #(
    parameter int DWIDTH    = 128,
    parameter int ADDRWIDTH = 32,
    parameter int IDWIDTH   = 4
);
    logic [IDWIDTH-1:0]   user_awid;
    logic [ADDRWIDTH-1:0] user_awaddr;
    logic [7:0]           user_awlen;
    logic [2:0]           user_awsize;
    logic [1:0]           user_awburst;
    logic                 user_awvalid;
    logic                 user_awready;

    logic [DWIDTH-1:0]    user_wdata;
    logic [DWIDTH/8-1:0]  user_wstrb;
    logic                 user_wlast;
    logic                 user_wvalid;
    logic                 user_wready;

    logic [IDWIDTH-1:0]   user_bid;
    logic [1:0]           user_bresp;
    logic                 user_bvalid;
    logic                 user_bready;

    logic [IDWIDTH-1:0]   user_arid;
    logic [ADDRWIDTH-1:0] user_araddr;
    logic [7:0]           user_arlen;
    logic [2:0]           user_arsize;
    logic [1:0]           user_arburst;
    logic                 user_arvalid;
    logic                 user_arready;

    logic [IDWIDTH-1:0]   user_rid;
    logic [DWIDTH-1:0]    user_rdata;
    logic [1:0]           user_rresp;
    logic                 user_rlast;
    logic                 user_rvalid;
    logic                 user_rready;

    modport master (
        output user_awid, user_awaddr, user_awlen, user_awsize, user_awburst, user_awvalid,
        input  user_awready,
        output user_wdata, user_wstrb, user_wlast, user_wvalid,
        input  user_wready,
        input  user_bid, user_bresp, user_bvalid,
        output user_bready,
        output user_arid, user_araddr, user_arlen, user_arsize, user_arburst, user_arvalid,
        input  user_arready,
        input  user_rid, user_rdata, user_rresp, user_rlast, user_rvalid,
        output user_rready
    );

    modport slave (
        input  user_awid, user_awaddr, user_awlen, user_awsize, user_awburst, user_awvalid,
        output user_awready,
        input  user_wdata, user_wstrb, user_wlast, user_wvalid,
        output user_wready,
        output user_bid, user_bresp, user_bvalid,
        input  user_bready,
        input  user_arid, user_araddr, user_arlen, user_arsize, user_arburst, user_arvalid,
        output user_arready,
        output user_rid, user_rdata, user_rresp, user_rlast, user_rvalid,
        input  user_rready
    );
endinterface

// File: rtl/aximm_leader_traffic_gen.sv
// AXI4 leader traffic generator: one INCR write or read burst per command, patterned data, B/R response checks.
// Read-data compare is built only when AXIMM_LDR_RDCHK_EN is defined; otherwise o_mismatch_cnt is tied to 0.
module aximm_leader_traffic_gen #(
    parameter int          DWIDTH    = 128,
    parameter int          ADDRWIDTH = 32,
    parameter int          IDWIDTH   = 4,
    parameter logic [31:0] SEED      = 32'h0000_0001
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start_wr,
    input  logic                 i_start_rd,
    input  logic [7:0]           i_cfg_len,
    input  logic [ADDRWIDTH-1:0] i_cfg_addr,
    input  logic [IDWIDTH-1:0]   i_cfg_id,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err_resp,
    output logic                 o_err_last,
    output logic [15:0]          o_mismatch_cnt,
    aximm_leader_traffic_gen_if.master bus
);
    localparam int          NLANE  = DWIDTH / 32;
    localparam logic [2:0]  AXSIZE = 3'($clog2(DWIDTH / 8));

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_len;
    logic [ADDRWIDTH-1:0] r_addr;
    logic [IDWIDTH-1:0]   r_id;
    logic [7:0]           r_beat;
    logic                 r_awvalid;
    logic                 r_wvalid;
    logic                 r_arvalid;
    logic                 r_over;
    logic                 r_done;
    logic                 r_err_resp;
    logic                 r_err_last;

    logic                 w_go_wr;
    logic                 w_go_rd;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_last_beat;
    logic                 w_b_hs;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_bready;
    logic                 w_rready;
    logic                 w_busy;
    logic [DWIDTH-1:0]    w_pattern;

    assign w_go_wr     = (r_state == S_IDLE) && i_start_wr;
    assign w_go_rd     = (r_state == S_IDLE) && i_start_rd && !i_start_wr;
    assign w_aw_hs     = r_awvalid && bus.user_awready;
    assign w_w_hs      = r_wvalid && bus.user_wready;
    assign w_last_beat = (r_beat == r_len);
    assign w_b_hs      = (r_state == S_WR_RESP) && bus.user_bvalid;
    assign w_ar_hs     = r_arvalid && bus.user_arready;
    assign w_r_hs      = (r_state == S_RD_DATA) && bus.user_rvalid;

    // Lane k of beat n carries SEED + n*NLANE + k; the same counter indexes write and read beats.
    always_comb begin
        w_pattern = '0;
        for (int k = 0; k < NLANE; k++) begin
            w_pattern[k*32 +: 32] = SEED + ({24'd0, r_beat} * 32'(NLANE)) + 32'(k);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_bready = 1'b0;
        w_rready = 1'b0;
        w_busy   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_go_wr) begin
                    w_next = S_WR;
                end else if (w_go_rd) begin
                    w_next = S_RD_ADDR;
                end
            end
            S_WR: begin
                // AW and the final W beat may complete in either order or together.
                if ((!r_awvalid || w_aw_hs) && (!r_wvalid || (w_w_hs && w_last_beat))) begin
                    w_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                w_bready = 1'b1;
                if (bus.user_bvalid) begin
                    w_next = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                w_rready = 1'b1;
                if (w_r_hs && bus.user_rlast) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len      <= '0;
            r_addr     <= '0;
            r_id       <= '0;
            r_beat     <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_over     <= 1'b0;
            r_done     <= 1'b0;
            r_err_resp <= 1'b0;
            r_err_last <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go_wr || w_go_rd) begin
                        r_len      <= i_cfg_len;
                        r_addr     <= i_cfg_addr;
                        r_id       <= i_cfg_id;
                        r_beat     <= '0;
                        r_over     <= 1'b0;
                        r_err_resp <= 1'b0;
                        r_err_last <= 1'b0;
                        r_awvalid  <= w_go_wr;
                        r_wvalid   <= w_go_wr;
                        r_arvalid  <= w_go_rd;
                    end
                end
                S_WR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        if (w_last_beat) begin
                            r_wvalid <= 1'b0;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (bus.user_bvalid) begin
                        if (bus.user_bresp != 2'b00) begin
                            r_err_resp <= 1'b1;
                        end
                        r_done <= 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_beat <= r_beat + 8'd1;
                        if (bus.user_rresp != 2'b00) begin
                            r_err_resp <= 1'b1;
                        end
                        // Once past the expected last beat the error is already flagged; just drain to rlast.
                        if (!r_over && (bus.user_rlast != w_last_beat)) begin
                            r_err_last <= 1'b1;
                        end
                        if (!bus.user_rlast && w_last_beat) begin
                            r_over <= 1'b1;
                        end
                        if (bus.user_rlast) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AXIMM_LDR_RDCHK_EN
    logic        r_cmp_bad;
    logic [15:0] r_mm_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmp_bad <= 1'b0;
            r_mm_cnt  <= '0;
        end else begin
            r_cmp_bad <= w_r_hs && (bus.user_rdata != w_pattern);
            if (w_go_rd) begin
                r_mm_cnt <= '0;
            end else if (r_cmp_bad && (r_mm_cnt != 16'hFFFF)) begin
                r_mm_cnt <= r_mm_cnt + 16'd1;
            end
        end
    end

    assign o_mismatch_cnt = r_mm_cnt;
`else
    assign o_mismatch_cnt = '0;
`endif

    assign o_busy     = w_busy;
    assign o_done     = r_done;
    assign o_err_resp = r_err_resp;
    assign o_err_last = r_err_last;

    // Payloads are zeroed whenever their valid is low, so idle and reset outputs read as 0.
    assign bus.user_awvalid = r_awvalid;
    assign bus.user_awid    = r_awvalid ? r_id   : '0;
    assign bus.user_awaddr  = r_awvalid ? r_addr : '0;
    assign bus.user_awlen   = r_awvalid ? r_len  : 8'd0;
    assign bus.user_awsize  = r_awvalid ? AXSIZE : 3'd0;
    assign bus.user_awburst = r_awvalid ? 2'b01  : 2'b00;

    assign bus.user_wvalid  = r_wvalid;
    assign bus.user_wdata   = r_wvalid ? w_pattern : '0;
    assign bus.user_wstrb   = r_wvalid ? '1 : '0;
    assign bus.user_wlast   = r_wvalid && w_last_beat;

    assign bus.user_bready  = w_bready;

    assign bus.user_arvalid = r_arvalid;
    assign bus.user_arid    = r_arvalid ? r_id   : '0;
    assign bus.user_araddr  = r_arvalid ? r_addr : '0;
    assign bus.user_arlen   = r_arvalid ? r_len  : 8'd0;
    assign bus.user_arsize  = r_arvalid ? AXSIZE : 3'd0;
    assign bus.user_arburst = r_arvalid ? 2'b01  : 2'b00;

    assign bus.user_rready  = w_rready;
endmodule

// File: tb/tb_aximm_leader_traffic_gen.sv
// Directed and randomized bursts against a behavioural subordinate and pattern model.
module tb_aximm_leader_traffic_gen;
    localparam int          DW   = 128;
    localparam int          AW   = 32;
    localparam int          IW   = 4;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_wr, start_rd;
    logic [7:0]    cfg_len;
    logic [AW-1:0] cfg_addr;
    logic [IW-1:0] cfg_id;
    logic          busy, done, err_resp, err_last;
    logic [15:0]   mismatch_cnt;

    int vecs = 0;
    int errs = 0;
    int m_mismatch = 0;

    always #5 clk = ~clk;

    aximm_leader_traffic_gen_if #(.DWIDTH(DW), .ADDRWIDTH(AW), .IDWIDTH(IW)) bus ();

    aximm_leader_traffic_gen #(.DWIDTH(DW), .ADDRWIDTH(AW), .IDWIDTH(IW), .SEED(SEED)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start_wr    (start_wr),
        .i_start_rd    (start_rd),
        .i_cfg_len     (cfg_len),
        .i_cfg_addr    (cfg_addr),
        .i_cfg_id      (cfg_id),
        .o_busy        (busy),
        .o_done        (done),
        .o_err_resp    (err_resp),
        .o_err_last    (err_last),
        .o_mismatch_cnt(mismatch_cnt),
        .bus           (bus.master)
    );

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Lane k of beat n = SEED + n*(DW/32) + k, modulo 2^32.
    function automatic logic [DW-1:0] pat(input int n);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = SEED + 32'(n * (DW / 32) + k);
        return v;
    endfunction

    function automatic logic [123:0] ctl_outs();
        return {busy, done, err_resp, err_last, mismatch_cnt,
                bus.user_awvalid, bus.user_awid, bus.user_awaddr, bus.user_awlen, bus.user_awsize,
                bus.user_awburst, bus.user_wvalid, bus.user_wlast,
                bus.user_arvalid, bus.user_arid, bus.user_araddr, bus.user_arlen, bus.user_arsize,
                bus.user_arburst, bus.user_bready, bus.user_rready};
    endfunction

    task automatic check_all_zero(input string tag);
        chkw({tag, "_ctl"},  128'(ctl_outs()), 128'd0);
        chkw({tag, "_wdat"}, bus.user_wdata, 128'd0);
        chkw({tag, "_strb"}, 128'(bus.user_wstrb), 128'd0);
    endtask

    task automatic idle_check();
        @(posedge clk); @(negedge clk);
        chk1("idle_done", done, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        chkw("idle_mismatch", 128'(mismatch_cnt), 128'(m_mismatch));
    endtask

    // Called at a negedge; returns at the negedge on which done must be high.
    task automatic do_write(input int len, input int addr, input int id, input int aw_delay,
                            input int wmode, input logic [1:0] bresp, input bit both, input bit rd_noise);
        int  beat, c;
        bit  aw_done, w_done, fin;
        cfg_len = 8'(len); cfg_addr = 32'(addr); cfg_id = 4'(id);
        start_wr = 1'b1; start_rd = both;
        @(posedge clk); @(negedge clk);
        start_wr = 1'b0; start_rd = 1'b0;
        beat = 0; c = 0; aw_done = 0; w_done = 0; fin = 0;
        while (!fin && c < 300) begin
            chk1("wr_busy", busy, 1'b1);
            chk1("wr_done_low", done, 1'b0);
            chk1("wr_err_resp_clr", err_resp, 1'b0);
            chk1("wr_err_last_clr", err_last, 1'b0);
            chkw("wr_mismatch", 128'(mismatch_cnt), 128'(m_mismatch));
            chk1("wr_arvalid", bus.user_arvalid, 1'b0);
            chk1("wr_awvalid", bus.user_awvalid, !aw_done);
            if (!aw_done) begin
                chkw("wr_awaddr", 128'(bus.user_awaddr), 128'(cfg_addr));
                chkw("wr_awlen", 128'(bus.user_awlen), 128'(cfg_len));
                chkw("wr_awid", 128'(bus.user_awid), 128'(cfg_id));
                chkw("wr_awsize", 128'(bus.user_awsize), 128'd4);
                chkw("wr_awburst", 128'(bus.user_awburst), 128'd1);
            end
            chk1("wr_wvalid", bus.user_wvalid, !w_done);
            if (!w_done) begin
                chkw("wr_wdata", bus.user_wdata, pat(beat));
                chk1("wr_wlast", bus.user_wlast, beat == len);
                chkw("wr_wstrb", 128'(bus.user_wstrb), 128'hFFFF);
            end
            chk1("wr_bready", bus.user_bready, aw_done && w_done);
            if (aw_done && w_done) begin
                bus.user_bvalid = 1'b1; bus.user_bresp = bresp; bus.user_bid = 4'(id);
                bus.user_awready = 1'b0; bus.user_wready = 1'b0; start_rd = 1'b0;
                @(posedge clk); @(negedge clk);
                bus.user_bvalid = 1'b0; bus.user_bresp = 2'b00;
                chk1("wr_done_pulse", done, 1'b1);
                chk1("wr_busy_fall", busy, 1'b0);
                chk1("wr_err_resp", err_resp, bresp != 2'b00);
                chk1("wr_err_last", err_last, 1'b0);
                fin = 1;
            end else begin
                bus.user_awready = (c >= aw_delay);
                case (wmode)
                    0:       bus.user_wready = 1'b1;
                    1:       bus.user_wready = c[0];
                    default: bus.user_wready = 1'($urandom_range(0, 1));
                endcase
                start_rd = rd_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                if (!aw_done && bus.user_awready) aw_done = 1;
                if (!w_done && bus.user_wready) begin
                    if (beat == len) w_done = 1;
                    else beat++;
                end
                @(posedge clk); @(negedge clk);
                c++;
            end
        end
        chk1("wr_timeout", fin, 1'b1);
    endtask

    // rlast_at: beat index carrying rlast; bad_beat/corrupt_beat < 0 disables that fault.
    task automatic do_read(input int len, input int addr, input int id, input int ar_delay,
                           input int rlast_at, input int bad_beat, input int corrupt_beat, input bit gap);
        int  n, c;
        bit  ar_done, fin, last_sent;
        cfg_len = 8'(len); cfg_addr = 32'(addr); cfg_id = 4'(id);
        start_rd = 1'b1;
        @(posedge clk); @(negedge clk);
        start_rd = 1'b0;
        m_mismatch = 0;
        chkw("rd_mismatch_clr", 128'(mismatch_cnt), 128'd0);
        chk1("rd_err_resp_clr", err_resp, 1'b0);
        chk1("rd_err_last_clr", err_last, 1'b0);
        n = 0; c = 0; ar_done = 0; fin = 0;
        while (!fin && c < 400) begin
            chk1("rd_busy", busy, 1'b1);
            chk1("rd_done_low", done, 1'b0);
            chk1("rd_awvalid", bus.user_awvalid, 1'b0);
            chk1("rd_wvalid", bus.user_wvalid, 1'b0);
            chk1("rd_bready", bus.user_bready, 1'b0);
            chk1("rd_arvalid", bus.user_arvalid, !ar_done);
            chk1("rd_rready", bus.user_rready, ar_done);
            if (!ar_done) begin
                chkw("rd_araddr", 128'(bus.user_araddr), 128'(cfg_addr));
                chkw("rd_arlen", 128'(bus.user_arlen), 128'(cfg_len));
                chkw("rd_arid", 128'(bus.user_arid), 128'(cfg_id));
                chkw("rd_arsize", 128'(bus.user_arsize), 128'd4);
                chkw("rd_arburst", 128'(bus.user_arburst), 128'd1);
                bus.user_arready = (c >= ar_delay);
                if (bus.user_arready) ar_done = 1;
                last_sent = 0;
            end else begin
                bus.user_arready = 1'b0;
                bus.user_rvalid  = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.user_rdata   = pat(n) ^ ((n == corrupt_beat) ? 128'd1 : 128'd0);
                bus.user_rlast   = (n == rlast_at);
                bus.user_rresp   = (n == bad_beat) ? 2'b10 : 2'b00;
                bus.user_rid     = 4'(id);
                last_sent = bus.user_rvalid && bus.user_rlast;
                if (bus.user_rvalid) n++;
            end
            @(posedge clk); @(negedge clk);
            c++;
            if (last_sent) begin
                bus.user_rvalid = 1'b0; bus.user_rlast = 1'b0; bus.user_rresp = 2'b00;
                chk1("rd_done_pulse", done, 1'b1);
                chk1("rd_busy_fall", busy, 1'b0);
                chk1("rd_err_last", err_last, rlast_at != len);
                chk1("rd_err_resp", err_resp, bad_beat >= 0 && bad_beat <= rlast_at);
                fin = 1;
            end
        end
        bus.user_rvalid = 1'b0;
        chk1("rd_timeout", fin, 1'b1);
`ifdef AXIMM_LDR_RDCHK_EN
        if (corrupt_beat >= 0 && corrupt_beat <= rlast_at) m_mismatch++;
`endif
    endtask

    initial begin
        rst_n = 1'b0; start_wr = 1'b0; start_rd = 1'b0;
        cfg_len = '0; cfg_addr = '0; cfg_id = '0;
        bus.user_awready = 1'b0; bus.user_wready = 1'b0; bus.user_arready = 1'b0;
        bus.user_bvalid = 1'b0; bus.user_bresp = 2'b00; bus.user_bid = '0;
        bus.user_rvalid = 1'b0; bus.user_rdata = '0; bus.user_rresp = 2'b00;
        bus.user_rlast = 1'b0; bus.user_rid = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_write(3, 32'h1000, 5, 0, 0, 2'b00, 0, 0);
        idle_check();
        do_write(3, 32'h2000, 2, 5, 1, 2'b00, 0, 0);
        idle_check();
        do_read(7, 32'h3000, 1, 0, 7, -1, -1, 0);
        idle_check();
        do_read(7, 32'h3100, 3, 2, 7, -1, 2, 1);
        idle_check();
        do_read(7, 32'h3200, 4, 0, 5, -1, -1, 0);
        idle_check();
        do_read(3, 32'h3300, 6, 1, 5, 1, -1, 1);
        idle_check();
        do_write(2, 32'h4000, 7, 1, 2, 2'b10, 0, 0);
        idle_check();
        do_write(4, 32'h5000, 8, 2, 0, 2'b00, 1, 1);
        idle_check();
        do_write(0, 32'h6000, 9, 0, 0, 2'b00, 0, 0);
        do_read(2, 32'h7000, 10, 0, 2, -1, 2, 0);
        do_write(1, 32'h7100, 11, 0, 0, 2'b00, 0, 0);
        idle_check();

        cfg_len = 8'd7; cfg_addr = 32'h8000; cfg_id = 4'd12;
        start_wr = 1'b1;
        @(posedge clk); @(negedge clk);
        start_wr = 1'b0; bus.user_awready = 1'b1; bus.user_wready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        bus.user_awready = 1'b0; bus.user_wready = 1'b0;
        @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        m_mismatch = 0;
        @(negedge clk);
        chk1("rst_no_done", done, 1'b0);
        do_write(2, 32'h9000, 13, 0, 0, 2'b00, 0, 0);
        idle_check();

        for (int i = 0; i < 12; i++) begin
            int len, rl;
            len = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(len, int'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)),
                         ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len + 2)) : len;
                do_read(len, int'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), rl,
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rl)) : -1,
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rl)) : -1, 1'b1);
            end
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
